// File: rtl/vga_image_fetch_ctrl.sv
// Image ROM fetch sequencer for the VGA path: running pixel address counter, shared
// R/G/B ROM address, flag realignment to the ROM latency, and end-of-image / desync pulses.
module vga_image_fetch_ctrl #(
    parameter int          IMG_W = 400,
    parameter int          IMG_H = 400,
    parameter int          X0    = 120,
    parameter int          Y0    = 40,
    parameter logic [23:0] BG    = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    output logic [31:0] rom_addr,
    input  logic [7:0]  rom_r,
    input  logic [7:0]  rom_g,
    input  logic [7:0]  rom_b,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_done,
    output logic        sync_err
);

    localparam int               CNT_W = 18;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [10:0]      X_LO  = 11'(X0);
    localparam logic [10:0]      X_HI  = 11'(X0 + IMG_W);
    localparam logic [10:0]      Y_LO  = 11'(Y0);
    localparam logic [10:0]      Y_HI  = 11'(Y0 + IMG_H);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        DONE       = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_frame_done_nxt;
    logic               w_sync_err_nxt;
    logic               w_in_win;
    logic               w_fs;
    logic               w_live;
    logic               r_win_d1;
    logic               r_video_on_d1;

    assign w_in_win = video_on
                   && ({1'b0, hcount} >= X_LO) && ({1'b0, hcount} < X_HI)
                   && ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} < Y_HI);

    assign w_fs = pix_en && (hcount == 10'd0) && (vcount == 10'd0);

    // A pixel is a real image fetch only in ACTIVE, or on the frame-start pixel itself.
    assign w_live = (r_state == ACTIVE) || w_fs;

    assign rom_addr = {{(32-CNT_W){1'b0}}, r_cnt};

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_frame_done_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;

        if (w_fs) begin
            w_state_nxt    = ACTIVE;
            w_sync_err_nxt = (r_state == ACTIVE) && (r_cnt != '0);
            w_cnt_nxt      = w_in_win ? CNT_W'(1) : '0;
        end else begin
            case (r_state)
                WAIT_FRAME: w_cnt_nxt = '0;
                DONE:       w_cnt_nxt = '0;
                ACTIVE: begin
                    if (pix_en && w_in_win) begin
                        if (r_cnt == LAST) begin
                            w_cnt_nxt        = '0;
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = DONE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = WAIT_FRAME;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= WAIT_FRAME;
            r_cnt      <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            frame_done <= w_frame_done_nxt;
            sync_err   <= w_sync_err_nxt;
        end
    end

    // Stage 1 matches the ROM's registered read; the colour register below is stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_d1      <= 1'b0;
            r_video_on_d1 <= 1'b0;
            red           <= 8'd0;
            green         <= 8'd0;
            blue          <= 8'd0;
        end else begin
            r_win_d1      <= w_in_win && w_live;
            r_video_on_d1 <= video_on;
            if (r_win_d1) begin
                {red, green, blue} <= {rom_r, rom_g, rom_b};
            end else if (r_video_on_d1) begin
                {red, green, blue} <= BG;
            end else begin
                {red, green, blue} <= 24'd0;
            end
        end
    end

endmodule
